wb_imem_loader: RTL and testbench
=================================

Name: wb_imem_loader

Overview:
- Wishbone classic responder on the Caravel management bus (wbs_* side of the user wrapper) for the 16-bit pipelined RISC core.
- Lets firmware hold the core in reset, load and read back its instruction memory, start and stop execution, and read core status (halted flag, PC).
- Sits between the wrapper's wbs_* ports and the core/imem ports inside the user project macro.

Parameters:
- BASE_ADDR, 32'h3000_0000, region base; decoded on wbs_adr_i[31:16].
- IMEM_AW, 8, instruction-memory word address width (depth 2**IMEM_AW x 16-bit).

Ports:
- wb_clk_i  in  1  sole clock; all logic is rising-edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- core_rst_o  out  1  soft reset to core, active-high.
- core_run_o  out  1  core enable.
- core_halted_i  in  1  core executed HALT.
- core_pc_i  in  16  core program counter.
- imem_we_o  out  1  imem write strobe.
- imem_addr_o  out  IMEM_AW  imem word address.
- imem_wdata_o  out  16  imem write data.
- imem_rdata_i  in  16  imem read data; synchronous, valid one cycle after the address is presented.

Behaviour:
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0.
  - core_rst_o=1, core_run_o=0, viol=0, FSM=IDLE.
- Select: sel = cyc&stb&(adr[31:16]==BASE_ADDR[31:16]). No ack is ever issued for unselected addresses.
- Map (offset = adr[15:0]):
  - 0x0000 CTRL RW: bit0 run, bit1 rst. A write updates the register only if sel[0]=1. Read returns {30'b0, rst, run}.
  - 0x0004 STATUS RO: {pc[15:0], 13'b0, viol, 1'b0, halted}. A write with dat[2]=1 and sel[0]=1 clears viol; all other bits are ignored.
  - 0x1000 + 4*i, i < 2**IMEM_AW: IMEM word i, data[15:0]. Reads return {16'b0, word}.
  - Any other offset in the region: ack, read returns 0, write has no effect.
- IMEM access is legal only while core_rst_o=1 or core_run_o=0.
  - Illegal write: dropped, viol set, still acked.
  - Illegal read: returns 0, viol set, acked.
  - An IMEM write with sel[1:0] != 2'b11 is dropped silently (viol unchanged).
- FSM states: IDLE, RD_WAIT, ACK.
  - IDLE -> RD_WAIT on a legal IMEM read; imem_addr_o=adr[IMEM_AW+1:2] is driven that cycle.
  - IDLE -> ACK on any other selected access. Register and IMEM writes take effect on this edge; imem_we_o pulses for exactly 1 cycle.
  - RD_WAIT -> ACK: capture imem_rdata_i into wbs_dat_o.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. wbs_dat_o is valid in the same cycle as ack.
- Latency from stb assertion to ack high: 1 cycle for writes and register reads; 2 cycles for IMEM reads.
- ack never stays high two consecutive cycles. A back-to-back strobe is accepted in IDLE only.
- cyc deasserted while in RD_WAIT: abort to IDLE, no ack.
- wb_rst_n asserted at any time: immediate return to reset values, including mid-transaction. The pending ack is lost.
- viol set and cleared on the same edge: set wins.
- core_halted_i and core_pc_i are sampled combinationally at the read.

Test Plan:
- Reset release -> core_rst_o=1, core_run_o=0, ack=0. Read 0x3000_0000 -> 0x0000_0002, ack exactly 1 cycle after stb.
- Write IMEM words 0..3 = 0x1111, 0x2222, 0x3333, 0x4444 with core held in rst -> 4 single-cycle imem_we_o pulses at addresses 0..3. Readback of 0x3000_1004 returns 0x0000_2222, ack 2 cycles after stb.
- Write CTRL=0x1 (run, rst released), then write IMEM 0x3000_1000=0xBEEF -> no imem_we_o pulse, ack still issued. STATUS bit2=1; clearing with a write of 0x4 to 0x3000_0004 -> bit2=0.
- core_pc_i=0x00A5, core_halted_i=1 -> STATUS read = 0x00A5_0001. Access to 0x3100_0000 -> ack never asserts within 16 cycles.
- IMEM read started, cyc dropped in RD_WAIT -> no ack, FSM back in IDLE. A following CTRL read acks normally.
- wb_rst_n pulsed low during RD_WAIT -> ack stays 0, CTRL returns to 0x2, the next transaction completes normally.

Source files
------------

// File: rtl/wb_imem_loader.sv
// Wishbone classic responder that loads and reads back the core's
// instruction memory and exposes core run/reset control and status.
//
// Ports:
//   wb_clk_i, wb_rst_n      clock, async active-low reset
//   wbs_cyc_i..wbs_dat_i    Wishbone classic slave inputs
//   wbs_ack_o, wbs_dat_o    Wishbone acknowledge and read data
//   core_rst_o, core_run_o  core soft reset (active-high) and run enable
//   core_halted_i, core_pc_i core status, sampled at the STATUS read
//   imem_we_o, imem_addr_o, imem_wdata_o, imem_rdata_i
//                           synchronous instruction-memory port

module wb_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IMEM_AW   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               core_rst_o,
  output logic               core_run_o,
  input  logic               core_halted_i,
  input  logic [15:0]        core_pc_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [15:0]        imem_wdata_o,
  input  logic [15:0]        imem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    ACK
  } state_e;

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                we_q, we_d;
  logic [IMEM_AW-1:0]  addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                rst_q, rst_d;
  logic                viol_q, viol_d;

  logic                hit;
  logic [15:0]         off;
  logic [15:0]         ioff;
  logic                is_ctrl;
  logic                is_stat;
  logic                is_imem;
  logic                imem_ok;
  logic [IMEM_AW-1:0]  word;
  logic                unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  assign hit  = wbs_cyc_i & wbs_stb_i &
                (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign off  = wbs_adr_i[15:0];
  assign ioff = off - 16'h1000;
  assign word = wbs_adr_i[IMEM_AW+1:2];

  assign is_ctrl = (off == 16'h0000);
  assign is_stat = (off == 16'h0004);
  assign is_imem = (off >= 16'h1000) &&
                   ((ioff >> (IMEM_AW + 2)) == 16'd0) &&
                   (off[1:0] == 2'b00);

  // The core must not fetch while the loader touches its memory.
  assign imem_ok = rst_q | ~run_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    rst_d   = rst_q;
    viol_d  = viol_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = '0;
          unique case (1'b1)
            is_ctrl: begin
              if (wbs_we_i) begin
                if (wbs_sel_i[0]) begin
                  run_d = wbs_dat_i[0];
                  rst_d = wbs_dat_i[1];
                end
              end else begin
                dat_d = {30'b0, rst_q, run_q};
              end
            end
            is_stat: begin
              if (wbs_we_i) begin
                if (wbs_sel_i[0] & wbs_dat_i[2]) viol_d = 1'b0;
              end else begin
                dat_d = {core_pc_i, 13'b0, viol_q,
                         1'b0, core_halted_i};
              end
            end
            is_imem: begin
              addr_d = word;
              if (!imem_ok) begin
                viol_d = 1'b1;
              end else if (!wbs_we_i) begin
                // Address already presented combinationally this
                // cycle; data arrives during RD_WAIT.
                state_d = RD_WAIT;
                ack_d   = 1'b0;
              end else if (wbs_sel_i[1:0] == 2'b11) begin
                we_d    = 1'b1;
                wdata_d = wbs_dat_i[15:0];
              end
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = {16'b0, imem_rdata_i};
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      rst_q   <= 1'b1;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      rst_q   <= rst_d;
      viol_q  <= viol_d;
    end
  end

  // A synchronous memory needs the read address one edge early, so
  // the decoded word address bypasses the register while in IDLE.
  assign imem_addr_o  = (state_q == IDLE && hit && is_imem) ?
                        word : addr_q;
  assign imem_we_o    = we_q;
  assign imem_wdata_o = wdata_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign core_rst_o   = rst_q;
  assign core_run_o   = run_q;

endmodule

// File: tb/tb_wb_imem_loader.sv
// Directed bench for wb_imem_loader with a synchronous imem model.
// Prints one summary line: CHECKS n ERRORS m.

module tb_wb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        core_rst, core_run;
  logic        halted;
  logic [15:0] pc;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [15:0] imem_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  int          n_we = 0;
  int          we_long = 0;
  logic        we_prev = 1'b0;
  logic [7:0]  log_a [16];
  logic [15:0] log_d [16];

  always #5 clk = ~clk;

  wb_imem_loader dut (
    .wb_clk_i      (clk),
    .wb_rst_n      (rst_n),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat_i),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_o),
    .core_rst_o    (core_rst),
    .core_run_o    (core_run),
    .core_halted_i (halted),
    .core_pc_i     (pc),
    .imem_we_o     (imem_we),
    .imem_addr_o   (imem_addr),
    .imem_wdata_o  (imem_wdata),
    .imem_rdata_i  (imem_rdata)
  );

  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    imem_rdata <= mem[imem_addr];
  end

  always @(negedge clk) begin
    if (imem_we) begin
      if (we_prev) we_long++;
      if (n_we < 16) begin
        log_a[n_we] = imem_addr;
        log_d[n_we] = imem_wdata;
      end
      n_we++;
    end
    we_prev = imem_we;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rd,
                      output logic [31:0] lat);
    bit got_ack = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = wr;
    adr = a; dat_i = d; sel = s;
    rd = '0; lat = '1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        rd = dat_o;
        lat = 32'(i);
        got_ack = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (got_ack) begin
      @(posedge clk); #1;
      chk("ack_one_cycle", {31'b0, ack}, 32'd0);
    end
  endtask

  task automatic wr(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] rd, lat;
    xfer(1'b1, a, d, s, rd, lat);
    chk(tag, lat, 32'd1);
  endtask

  task automatic rd(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] exp,
                    input logic [31:0] exp_lat);
    logic [31:0] v, lat;
    xfer(1'b0, a, 32'd0, 4'hF, v, lat);
    chk(tag, v, exp);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; dat_i = '0;
    halted = 1'b0; pc = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst_core_run", {31'b0, core_run}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd("ctrl_reset", 32'h3000_0000, 32'h2, 32'd1);

    wr("imem_w0", 32'h3000_1000, 32'h1111, 4'hF);
    wr("imem_w1", 32'h3000_1004, 32'h2222, 4'hF);
    wr("imem_w2", 32'h3000_1008, 32'h3333, 4'hF);
    wr("imem_w3", 32'h3000_100C, 32'h4444, 4'hF);
    chk("we_count4", 32'(n_we), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("we_addr", {24'b0, log_a[i]}, 32'(i));
      chk("we_data", {16'b0, log_d[i]},
          32'(16'h1111 * (i + 1)));
    end
    rd("imem_r1", 32'h3000_1004, 32'h2222, 32'd2);
    rd("imem_r0", 32'h3000_1000, 32'h1111, 32'd2);

    wr("ctrl_run", 32'h3000_0000, 32'h1, 4'hF);
    rd("ctrl_run_rd", 32'h3000_0000, 32'h1, 32'd1);
    wr("imem_ill_w", 32'h3000_1000, 32'hBEEF, 4'hF);
    chk("ill_no_we", 32'(n_we), 32'd4);
    rd("stat_viol", 32'h3000_0004, 32'h4, 32'd1);
    wr("stat_clr", 32'h3000_0004, 32'h4, 4'hF);
    rd("stat_clr_rd", 32'h3000_0004, 32'h0, 32'd1);

    rd("imem_ill_r", 32'h3000_1008, 32'h0, 32'd1);
    rd("stat_viol_r", 32'h3000_0004, 32'h4, 32'd1);
    wr("stat_nosel", 32'h3000_0004, 32'h4, 4'hE);
    rd("stat_keep", 32'h3000_0004, 32'h4, 32'd1);
    wr("stat_clr2", 32'h3000_0004, 32'h4, 4'hF);
    rd("stat_clr2_rd", 32'h3000_0004, 32'h0, 32'd1);

    wr("ctrl_hold", 32'h3000_0000, 32'h2, 4'hF);
    wr("ctrl_nosel", 32'h3000_0000, 32'h1, 4'h2);
    rd("ctrl_keep", 32'h3000_0000, 32'h2, 32'd1);

    wr("imem_part", 32'h3000_1014, 32'h7777, 4'h1);
    chk("part_no_we", 32'(n_we), 32'd4);
    rd("part_no_viol", 32'h3000_0004, 32'h0, 32'd1);

    wr("imem_top_w", 32'h3000_13FC, 32'h5A5A, 4'hF);
    chk("top_we", 32'(n_we), 32'd5);
    chk("top_addr", {24'b0, log_a[4]}, 32'hFF);
    rd("imem_top_r", 32'h3000_13FC, 32'h5A5A, 32'd2);
    wr("past_w", 32'h3000_1400, 32'h9999, 4'hF);
    chk("past_no_we", 32'(n_we), 32'd5);
    rd("past_r", 32'h3000_1400, 32'h0, 32'd1);
    rd("other_r", 32'h3000_0008, 32'h0, 32'd1);

    pc = 16'h00A5; halted = 1'b1;
    rd("stat_pc", 32'h3000_0004, 32'h00A5_0001, 32'd1);
    pc = 16'h0; halted = 1'b0;

    rd("unsel", 32'h3100_0000, 32'h0, 32'hFFFF_FFFF);

    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 32'h3000_100C; sel = 4'hF;
    @(posedge clk); #1;
    chk("abort_wait", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {31'b0, ack}, 32'd0);
    end
    rd("abort_ctrl", 32'h3000_0000, 32'h2, 32'd1);

    wr("ctrl_3", 32'h3000_0000, 32'h3, 4'hF);
    rd("ctrl_3_rd", 32'h3000_0000, 32'h3, 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 32'h3000_1008; sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_run", {31'b0, core_run}, 32'd0);
    rst_n = 1'b1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ack", {31'b0, ack}, 32'd0);
    end
    rd("mid_rst_ctrl", 32'h3000_0000, 32'h2, 32'd1);
    rd("mid_rst_imem", 32'h3000_100C, 32'h4444, 32'd2);

    chk("we_single", 32'(we_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
